// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle, with single-cycle shortcuts for divide-by-zero and overflow.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic                a_neg_q, b_neg_q;
  logic [XLEN-1:0]     b_mag_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CW-1:0]       cnt_q;

  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0]     quo, rem, fix_res;

  // Operand decode: signedness, magnitudes and single-cycle special cases
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2:    a_signed = 1'b1;
      default: ;
    endcase
    a_neg       = a_signed & op_a[XLEN-1];
    b_neg       = b_signed & op_b[XLEN-1];
    a_mag       = a_neg ? -op_a : op_a;
    b_mag       = b_neg ? -op_b : op_b;
    div_zero    = funct3[2] && (op_b == '0);
    div_ovf     = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    special     = div_zero || div_ovf;
    accept      = (state_q == IDLE) && start && !kill;
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? op_a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, b_mag_q};
    if (div_diff[XLEN]) div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction and result selection
  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    if (!op_q[2])    fix_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1]) fix_res = a_neg_q ? -rem : rem;
    else             fix_res = (a_neg_q ^ b_neg_q) ? -quo : quo;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !kill) state_d = special ? DONE : CALC;
      CALC:    if (kill) state_d = IDLE;
               else if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = kill ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == CALC) || (state_d == FIX);
      done    <= (state_d == DONE);
    end
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      b_mag_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      result  <= '0;
    end else begin
      if (accept) begin
        op_q    <= funct3;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        b_mag_q <= b_mag;
        acc_q   <= {{XLEN{1'b0}}, a_mag};
        cnt_q   <= CW'(XLEN);
        if (special) result <= special_res;
      end else if (state_q == CALC) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q - CW'(1);
      end else if ((state_q == FIX) && !kill) begin
        result <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors push expected results,
// a monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got result 0x%08h with no operation pending", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_latency"}, 32'(cyc - e.t0 + 1), 32'(e.lat));
      end
    end
  end

  // Drive one start cycle from a negedge; optionally record the expected response
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] res, input int lat, input string name);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    if (push) sb.push_back('{res, lat, cyc + 1, name});
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: got no done after %0d cycles expected done", sb[0].name, n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input string name);
    issue(f, a, b, 1'b1, res, lat, name);
    drain();
  endtask

  initial begin
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'd6, 32'd42, 34, "mul_7x6");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max");
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 34, "mulh_m1xm1");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_m1");
    run_op(3'd0, 32'h12345678, 32'h10, 32'h23456780, 34, "mul_shift");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div_m7_2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem_m7_2");
    run_op(3'd5, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34, "divu_big");
    run_op(3'd7, 32'hFFFFFFF9, 32'd2, 32'h1, 34, "remu_big");
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu_by0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem_ovf");
    run_op(3'd0, 32'd7, 32'd6, 32'd42, 34, "mul_prekill");

    // Kill mid-CALC: no done, result keeps the previous value
    issue(3'd5, 32'd1000, 32'd3, 1'b0, 32'h0, 0, "killed");
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    chk("kill_result", result, 32'd42);
    repeat (40) @(negedge clk);

    // Start with kill in IDLE is discarded
    funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0;
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("startkill_busy", 32'(busy), 32'd0);
    chk("startkill_done", 32'(done), 32'd0);
    @(negedge clk);

    // Start pulsed while busy is ignored
    issue(3'd4, 32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 34, "div_busystart");
    repeat (4) @(negedge clk);
    issue(3'd0, 32'd1, 32'd1, 1'b0, 32'h0, 0, "ignored");
    drain();
    run_op(3'd6, 32'd100, 32'hFFFFFFF9, 32'd2, 34, "rem_100_m7");

    // Start held into the DONE cycle is ignored
    issue(3'd5, 32'd7, 32'd0, 1'b1, 32'hFFFFFFFF, 1, "divu_doneheld");
    funct3 = 3'd7; op_a = 32'd9; op_b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("donestart_busy", 32'(busy), 32'd0);
    chk("donestart_done", 32'(done), 32'd0);
    chk("donestart_result", result, 32'hFFFFFFFF);
    @(negedge clk);

    // Reset mid-CALC abandons the operation
    issue(3'd0, 32'd9, 32'd9, 1'b0, 32'h0, 0, "reset_victim");
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd5, 32'd15, 34, "mul_after_reset");

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have the parameter XLEN, default 32, giving the operand and result width and the iteration count.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have the port kill, input, 1 bit: abort the operation in flight (pipeline flush).
REQ-006 The block SHALL have the port funct3, input, 3 bits: RV32M op. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 The block SHALL have the ports op_a and op_b, input, XLEN bits each: rs1 and rs2 operands, sampled with start.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while an operation is in progress; drives the pipeline stall.
REQ-009 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The block SHALL have the port result, output, XLEN bits: the final value, held until the next accepted start.

Function
REQ-011 The FSM SHALL have the states IDLE, CALC, FIX and DONE, and SHALL reset to IDLE.
REQ-012 In IDLE, start=1 and kill=0 SHALL latch funct3, op_a and op_b, and move to CALC on the next edge.
- Exception: the special cases in REQ-017 and REQ-018 go straight to DONE.
REQ-013 CALC SHALL run exactly XLEN iterations from a down-counter, then move to FIX.
- Multiply: shift-add over the operand magnitudes into a 2*XLEN-bit product.
- Divide: restoring division over the operand magnitudes.
REQ-014 Operand magnitudes SHALL be taken at latch time as follows:
- Signed: MULH (both operands), MULHSU (op_a only), DIV and REM (both operands).
- Unsigned: all others.
REQ-015 FIX SHALL apply sign correction and select the result, then move to DONE:
- Product negated if exactly one signed source is negative.
- Quotient negated if the dividend and divisor signs differ.
- Remainder takes the dividend's sign.
- MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
REQ-016 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-017 Divide by zero (op_b=0, funct3 4-7) SHALL go IDLE->DONE in one cycle:
- DIV and DIVU: result all ones.
- REM and REMU: result op_a.
REQ-018 Signed overflow (DIV or REM, op_a=0x80000000, op_b=0xFFFFFFFF) SHALL go IDLE->DONE in one cycle:
- DIV: result 0x80000000.
- REM: result 0.
REQ-019 Normal latency SHALL be XLEN+2 cycles from the start edge to the done cycle (34 for XLEN=32).
REQ-020 busy SHALL be 1 in CALC and FIX, and in the cycle after start is accepted; otherwise 0.
REQ-021 start SHALL be ignored when the state is not IDLE.
REQ-022 kill=1 in CALC or FIX SHALL force IDLE on the next edge; done stays 0 and result is unchanged.
REQ-023 kill=1 together with start in IDLE SHALL cause the start to be discarded.
REQ-024 start in the DONE cycle SHALL be ignored; a new start is accepted from the following IDLE cycle.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force the following, independent of clk:
- state IDLE;
- busy=0 and done=0;
- result=0;
- internal counter, accumulator and operand registers cleared.
REQ-026 Reset asserted mid-CALC SHALL abandon the operation; no done pulse follows deassertion.
REQ-027 After rst_n rises, the first start SHALL be accepted on the first rising edge.

Verification
REQ-028 The bench SHALL cover MUL, MULHU and MULH:
- MUL op_a=7, op_b=6 -> done at cycle 34, result=42.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH -1 x -1 -> 0.
REQ-029 The bench SHALL cover signed divide and remainder:
- DIV -7/2 -> 0xFFFFFFFD (-3).
- REM -7/2 -> 0xFFFFFFFF (-1).
- DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-030 The bench SHALL cover divide by zero:
- DIVU 5/0 -> done one cycle after start, result 0xFFFFFFFF.
- REMU 5/0 -> 5.
REQ-031 The bench SHALL cover signed overflow:
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after one cycle.
- REM of the same operands -> 0.
REQ-032 The bench SHALL cover kill and start-while-busy:
- kill at cycle 10 of CALC -> IDLE next cycle, no done, prior result retained.
- start pulsed while busy -> ignored, original operation completes unchanged.
REQ-033 The bench SHALL cover reset mid-operation:
- rst_n low at cycle 20 of CALC -> busy=0, done=0 and result=0 immediately.
- A following MUL 3x5 -> 15 after 34 cycles.
